// File: rtl/irq_dispatch_seq_if.sv
// ---------------------------------------------------------------------------
// irq_dispatch_seq_if
//   Bundles the encoder-facing and CPU-facing signals of the interrupt
//   dispatch stage.
//
//   Handshake semantics: bus_pend/chan_in are a level-sampled request
//   that must hold steady for a settle window. cpu_irq is a level request
//   that stays high until the CPU raises cpu_ack (pulse or level) or the
//   ack window expires. cpu_vec stays frozen while cpu_irq is high and while
//   the channel is in service. cpu_eoi ends service. src_clr is a one-cycle
//   pulse back to the source when the CPU accepts the vector.
//
//   Modports:
//     master : environment / encoder + CPU side (drives inputs of the stage)
//     slave  : the dispatch stage itself
//
//   Signals:
//     bus_pend [2:0]         encoder bus-pending flags, bit0 = bus A (highest)
//     chan_in  [3:0]         encoder winning-channel code
//     cpu_irq                interrupt request to CPU (level)
//     cpu_vec  [5:0]         {bus_idx[1:0], chan[3:0]}
//     cpu_ack                CPU accepts vector
//     cpu_eoi                CPU end-of-interrupt pulse
//     src_clr                one-cycle clear pulse for the accepted channel
//     svc_mask [3*NCHAN-1:0] one-hot mask of in-service channel
//     err_tmo                sticky ack-timeout flag
//     err_ill                sticky illegal-channel flag
// ---------------------------------------------------------------------------
interface irq_dispatch_seq_if #(
    parameter int NCHAN = 9
);
    logic [2:0]         bus_pend;
    logic [3:0]         chan_in;
    logic               cpu_irq;
    logic [5:0]         cpu_vec;
    logic               cpu_ack;
    logic               cpu_eoi;
    logic               src_clr;
    logic [3*NCHAN-1:0] svc_mask;
    logic               err_tmo;
    logic               err_ill;

    modport master (
        output bus_pend, chan_in, cpu_ack, cpu_eoi,
        input  cpu_irq, cpu_vec, src_clr, svc_mask, err_tmo, err_ill
    );

    modport slave (
        input  bus_pend, chan_in, cpu_ack, cpu_eoi,
        output cpu_irq, cpu_vec, src_clr, svc_mask, err_tmo, err_ill
    );
endinterface

// File: rtl/irq_dispatch_seq.sv
// ---------------------------------------------------------------------------
// irq_dispatch_seq
//   Sequential dispatch stage behind the 27-channel combinational interrupt
//   priority encoder. The encoder's bus-pending flags and winning channel are
//   qualified over a settle window; once stable, a CPU interrupt is raised
//   with the {bus, channel} vector. The CPU acknowledges (or the request times
//   out), the source latch is cleared with a pulse, and the in-service
//   channel is masked back towards the encoder until end-of-interrupt.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        irq_dispatch_seq_if.slave (see interface for signal list)
//     dbg_state  current FSM state (0 IDLE, 1 SETTLE, 2 REQ, 3 SERVICE)
//
//   Parameters:
//     SETTLE_CYC  cycles the tag must stay stable before a request (1..15)
//     ACK_TMO     cycles cpu_irq may wait for cpu_ack (1..65535)
//     NCHAN       channels per bus; chan_in >= NCHAN is illegal
// ---------------------------------------------------------------------------
module irq_dispatch_seq #(
    parameter int SETTLE_CYC = 2,
    parameter int ACK_TMO    = 255,
    parameter int NCHAN      = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_dispatch_seq_if.slave    bus,
    output logic [1:0]           dbg_state
);

    localparam int NMASK = 3 * NCHAN;
    localparam int IW    = $clog2(NMASK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        REQ     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        cand_q, cand_d;
    logic [3:0]        stab_q, stab_d;
    logic [15:0]       ack_cnt_q, ack_cnt_d;
    logic              irq_q, irq_d;
    logic [5:0]        vec_q, vec_d;
    logic              clr_q, clr_d;
    logic [NMASK-1:0]  mask_q, mask_d;
    logic              tmo_q, tmo_d;
    logic              ill_q, ill_d;

    // -----------------------------------------------------------------------
    // Input decode
    // -----------------------------------------------------------------------
    logic       any_pend;
    logic [1:0] bus_idx;
    logic [5:0] tag;
    logic       tag_same;
    logic       settle_done;
    logic       cand_ill;
    logic       ack_expired;

    assign any_pend = |bus.bus_pend;

    // Lowest set bit wins: bus A has the highest priority.
    always_comb begin
        bus_idx = 2'd2;
        if (bus.bus_pend[0]) begin
            bus_idx = 2'd0;
        end else if (bus.bus_pend[1]) begin
            bus_idx = 2'd1;
        end
    end

    assign tag      = {bus_idx, bus.chan_in};
    assign tag_same = (tag == cand_q);

    // The count is checked before it is incremented, so the first stable
    // sample counts as 1 and the request issues SETTLE_CYC+1 edges after
    // bus_pend first appears.
    assign settle_done = tag_same && (stab_q == 4'(SETTLE_CYC));

    assign cand_ill = ({1'b0, cand_q[3:0]} >= 5'(NCHAN));

    // ack_cnt_q is 0 on the first REQ edge, so expiry at ACK_TMO-1 gives
    // cpu_irq exactly ACK_TMO cycles high. Ack is checked first and wins.
    assign ack_expired = (ack_cnt_q >= 16'(ACK_TMO - 1));

    // One-hot position of the in-service channel: bus_idx*NCHAN + chan.
    logic [IW-1:0]    svc_idx;
    logic [NMASK-1:0] svc_onehot;

    assign svc_idx    = IW'(vec_q[5:4]) * IW'(NCHAN) + IW'(vec_q[3:0]);
    assign svc_onehot = NMASK'(1) << svc_idx;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            stab_q    <= '0;
            ack_cnt_q <= '0;
            irq_q     <= 1'b0;
            vec_q     <= '0;
            clr_q     <= 1'b0;
            mask_q    <= '0;
            tmo_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            ack_cnt_q <= ack_cnt_d;
            irq_q     <= irq_d;
            vec_q     <= vec_d;
            clr_q     <= clr_d;
            mask_q    <= mask_d;
            tmo_q     <= tmo_d;
            ill_q     <= ill_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!any_pend) begin
                    state_d = IDLE;
                end else if (settle_done) begin
                    // An illegal channel is reported and dropped, never issued.
                    state_d = cand_ill ? IDLE : REQ;
                end
            end
            REQ: begin
                if (bus.cpu_ack) begin
                    state_d = SERVICE;
                end else if (ack_expired) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.cpu_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        cand_d    = cand_q;
        stab_d    = stab_q;
        ack_cnt_d = ack_cnt_q;
        irq_d     = irq_q;
        vec_d     = vec_q;
        clr_d     = 1'b0;          // src_clr is only ever a single-cycle pulse
        mask_d    = mask_q;
        tmo_d     = tmo_q;
        ill_d     = ill_q;

        case (state_q)
            IDLE: begin
                // Every entry into SETTLE starts a fresh window, including a
                // re-entry with the same tag straight after EOI.
                if (any_pend) begin
                    cand_d = tag;
                    stab_d = 4'd1;
                end
            end
            SETTLE: begin
                if (any_pend) begin
                    if (!tag_same) begin
                        cand_d = tag;
                        stab_d = 4'd1;
                    end else if (settle_done) begin
                        if (cand_ill) begin
                            ill_d = 1'b1;
                        end else begin
                            vec_d     = cand_q;
                            irq_d     = 1'b1;
                            ack_cnt_d = '0;
                        end
                    end else if (stab_q != 4'hF) begin
                        stab_d = stab_q + 4'd1;
                    end
                end
            end
            REQ: begin
                if (bus.cpu_ack) begin
                    irq_d  = 1'b0;
                    clr_d  = 1'b1;
                    mask_d = svc_onehot;
                end else if (ack_expired) begin
                    irq_d = 1'b0;
                    tmo_d = 1'b1;
                end else if (ack_cnt_q != 16'hFFFF) begin
                    ack_cnt_d = ack_cnt_q + 16'd1;
                end
            end
            SERVICE: begin
                // A level ack still high here is ignored, so no second clear.
                if (bus.cpu_eoi) begin
                    mask_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.cpu_irq  = irq_q;
    assign bus.cpu_vec  = vec_q;
    assign bus.src_clr  = clr_q;
    assign bus.svc_mask = mask_q;
    assign bus.err_tmo  = tmo_q;
    assign bus.err_ill  = ill_q;
    assign dbg_state    = state_q;

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    a_irq_only_in_req: assert property (@(posedge clk) disable iff (rst)
        irq_q |-> (state_q == REQ));

    a_clr_single_pulse: assert property (@(posedge clk) disable iff (rst)
        clr_q |=> !clr_q);

    a_mask_only_in_service: assert property (@(posedge clk) disable iff (rst)
        (mask_q != '0) == (state_q == SERVICE));

    a_mask_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(mask_q));

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// ---------------------------------------------------------------------------
// tb_irq_dispatch_seq
//   Directed bench for irq_dispatch_seq with default parameters
//   (SETTLE_CYC=2, ACK_TMO=255, NCHAN=9). Inputs change 1 ns after a rising
//   edge; outputs are sampled at the same point, i.e. after the edge settled.
// ---------------------------------------------------------------------------
module tb_irq_dispatch_seq;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    irq_dispatch_seq_if bus_if ();

    irq_dispatch_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [2:0] pend, input logic [3:0] chan);
        bus_if.bus_pend = pend;
        bus_if.chan_in  = chan;
    endtask

    // Pulse cpu_eoi for one edge and return with it low.
    task automatic eoi_pulse();
        bus_if.cpu_eoi = 1'b1;
        tick();
        bus_if.cpu_eoi = 1'b0;
    endtask

    logic saw_clr;

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        bus_if.bus_pend = 3'b000;
        bus_if.chan_in  = 4'd0;
        bus_if.cpu_ack  = 1'b0;
        bus_if.cpu_eoi  = 1'b0;

        // Reset state
        ticks(2);
        check("rst_irq",   32'(bus_if.cpu_irq),  32'd0);
        check("rst_vec",   32'(bus_if.cpu_vec),  32'd0);
        check("rst_clr",   32'(bus_if.src_clr),  32'd0);
        check("rst_mask",  32'(bus_if.svc_mask), 32'd0);
        check("rst_tmo",   32'(bus_if.err_tmo),  32'd0);
        check("rst_ill",   32'(bus_if.err_ill),  32'd0);
        check("rst_state", 32'(dbg_state),       32'd0);
        rst = 1'b0;
        tick();

        // 1) Bus A, chan 4: irq appears on the third edge
        drive(3'b001, 4'd4);
        tick();
        check("t1_e1_state", 32'(dbg_state),      32'd1);
        check("t1_e1_irq",   32'(bus_if.cpu_irq), 32'd0);
        tick();
        check("t1_e2_irq",   32'(bus_if.cpu_irq), 32'd0);
        tick();
        check("t1_e3_irq",   32'(bus_if.cpu_irq), 32'd1);
        check("t1_vec",      32'(bus_if.cpu_vec), 32'h04);

        // 2) Ack pulse -> one-cycle src_clr, mask bit 4, then EOI
        bus_if.cpu_ack = 1'b1;
        tick();
        bus_if.cpu_ack = 1'b0;
        check("t2_clr",   32'(bus_if.src_clr),  32'd1);
        check("t2_irq",   32'(bus_if.cpu_irq),  32'd0);
        check("t2_mask",  32'(bus_if.svc_mask), 32'h10);
        check("t2_state", 32'(dbg_state),       32'd3);
        tick();
        check("t2_clr_off", 32'(bus_if.src_clr),  32'd0);
        check("t2_mask_hd", 32'(bus_if.svc_mask), 32'h10);
        check("t2_vec_hd",  32'(bus_if.cpu_vec),  32'h04);
        eoi_pulse();
        check("t2_eoi_mask",  32'(bus_if.svc_mask), 32'd0);
        check("t2_eoi_state", 32'(dbg_state),       32'd0);

        // Same tag still pending: needs a fresh full settle window
        tick();
        check("t2_re_e1", 32'(bus_if.cpu_irq), 32'd0);
        tick();
        check("t2_re_e2", 32'(bus_if.cpu_irq), 32'd0);
        tick();
        check("t2_re_e3", 32'(bus_if.cpu_irq), 32'd1);

        // Level ack held across REQ->SERVICE: exactly one src_clr
        bus_if.cpu_ack = 1'b1;
        tick();
        check("t2_lvl_clr1", 32'(bus_if.src_clr), 32'd1);
        tick();
        check("t2_lvl_clr2", 32'(bus_if.src_clr), 32'd0);
        check("t2_lvl_st",   32'(dbg_state),      32'd3);
        tick();
        check("t2_lvl_clr3", 32'(bus_if.src_clr), 32'd0);
        bus_if.cpu_ack = 1'b0;
        drive(3'b000, 4'd0);
        eoi_pulse();
        tick();
        check("t2_idle", 32'(dbg_state), 32'd0);

        // 3) Bus B, chan toggling 2/5 every cycle never settles
        for (int i = 0; i < 8; i++) begin
            drive(3'b110, (i % 2) ? 4'd5 : 4'd2);
            tick();
            check("t3_toggle_irq", 32'(bus_if.cpu_irq), 32'd0);
        end
        // chan 5 was loaded on the last toggle edge; two more edges to irq
        tick();
        check("t3_hold_e2", 32'(bus_if.cpu_irq), 32'd0);
        tick();
        check("t3_hold_irq", 32'(bus_if.cpu_irq), 32'd1);
        check("t3_vec",      32'(bus_if.cpu_vec), 32'h15);
        // Encoder change ignored while in REQ
        drive(3'b001, 4'd7);
        tick();
        check("t3_vec_frozen", 32'(bus_if.cpu_vec), 32'h15);
        // Ack and EOI together in REQ: ack taken, EOI dropped
        bus_if.cpu_ack = 1'b1;
        bus_if.cpu_eoi = 1'b1;
        tick();
        bus_if.cpu_ack = 1'b0;
        bus_if.cpu_eoi = 1'b0;
        check("t3_ackeoi_st",   32'(dbg_state),       32'd3);
        check("t3_ackeoi_clr",  32'(bus_if.src_clr),  32'd1);
        check("t3_ackeoi_mask", 32'(bus_if.svc_mask), 32'h4000);
        drive(3'b000, 4'd0);
        tick();
        check("t3_still_svc", 32'(dbg_state), 32'd3);
        eoi_pulse();
        check("t3_eoi_st", 32'(dbg_state), 32'd0);

        // 4) Timeout: irq held 255 cycles, then dropped with err_tmo
        drive(3'b001, 4'd1);
        ticks(3);
        check("t4_irq", 32'(bus_if.cpu_irq), 32'd1);
        drive(3'b000, 4'd0);
        saw_clr = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick();
            saw_clr |= bus_if.src_clr;
        end
        check("t4_irq_254", 32'(bus_if.cpu_irq), 32'd1);
        check("t4_tmo_254", 32'(bus_if.err_tmo), 32'd0);
        tick();
        saw_clr |= bus_if.src_clr;
        check("t4_irq_255", 32'(bus_if.cpu_irq), 32'd0);
        check("t4_tmo_255", 32'(bus_if.err_tmo), 32'd1);
        check("t4_st_255",  32'(dbg_state),      32'd0);
        check("t4_no_clr",  32'(saw_clr),        32'd0);

        // Ack arriving on the expiry edge wins
        drive(3'b001, 4'd1);
        ticks(3);
        check("t4b_irq", 32'(bus_if.cpu_irq), 32'd1);
        drive(3'b000, 4'd0);
        ticks(254);
        bus_if.cpu_ack = 1'b1;
        tick();
        bus_if.cpu_ack = 1'b0;
        check("t4b_clr",  32'(bus_if.src_clr),  32'd1);
        check("t4b_st",   32'(dbg_state),       32'd3);
        check("t4b_mask", 32'(bus_if.svc_mask), 32'h2);
        check("t4b_tmo",  32'(bus_if.err_tmo),  32'd1);
        eoi_pulse();

        // Settle aborted when bus_pend drops
        drive(3'b001, 4'd3);
        tick();
        drive(3'b000, 4'd0);
        tick();
        check("abort_st", 32'(dbg_state), 32'd0);
        tick();
        check("abort_irq", 32'(bus_if.cpu_irq), 32'd0);

        // 5) Illegal channel 0xB on bus A
        drive(3'b001, 4'hB);
        tick();
        check("t5_e1_irq", 32'(bus_if.cpu_irq), 32'd0);
        tick();
        check("t5_e2_irq", 32'(bus_if.cpu_irq), 32'd0);
        tick();
        check("t5_ill",    32'(bus_if.err_ill), 32'd1);
        check("t5_irq",    32'(bus_if.cpu_irq), 32'd0);
        check("t5_st",     32'(dbg_state),      32'd0);
        drive(3'b000, 4'd0);
        ticks(3);
        check("t5_irq_late", 32'(bus_if.cpu_irq), 32'd0);

        // 6) Async reset while in SERVICE (bus C, chan 8 -> bit 26)
        drive(3'b100, 4'd8);
        ticks(3);
        check("t6_vec", 32'(bus_if.cpu_vec), 32'h28);
        bus_if.cpu_ack = 1'b1;
        tick();
        bus_if.cpu_ack = 1'b0;
        check("t6_mask", 32'(bus_if.svc_mask), 32'h400_0000);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_mask", 32'(bus_if.svc_mask), 32'd0);
        check("t6_rst_irq",  32'(bus_if.cpu_irq),  32'd0);
        check("t6_rst_vec",  32'(bus_if.cpu_vec),  32'd0);
        check("t6_rst_tmo",  32'(bus_if.err_tmo),  32'd0);
        check("t6_rst_ill",  32'(bus_if.err_ill),  32'd0);
        check("t6_rst_st",   32'(dbg_state),       32'd0);
        drive(3'b000, 4'd0);
        tick();
        rst = 1'b0;
        ticks(2);
        check("t6_post_st", 32'(dbg_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
